// File: rtl/divacc.sv
// Accumulating unsigned divider. The accumulator can be loaded, or divided in place
// by x using a restoring divider that handles one quotient bit per cycle.
// Quotient and remainder land in the accumulator and rem together, so they update
// at the same moment.
module divacc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             divzero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StDiv, StCommit} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] acc_q;
  // Dividend shifts out at the MSB while quotient bits shift in at the LSB, so after
  // WIDTH steps this register holds the quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] prem_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             take;
  logic             unused_diff_msb;

  // One restoring step: shift in the next dividend bit, then try to subtract.
  always_comb begin
    shifted = {prem_q, dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    take    = (shifted >= {1'b0, dvs_q});
  end

  // After a successful subtract the difference is below the divisor, so its MSB is 0.
  assign unused_diff_msb = diff[WIDTH];

  assign busy = (state_q != StIdle);

  // Control FSM with the accumulator, outputs and divider datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= WIDTH'(1);
      out     <= WIDTH'(1);
      rem     <= '0;
      divzero <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            acc_q <= x;
            out   <= x;
            rem   <= '0;
          end else if (en) begin
            if (x == '0) begin
              divzero <= 1'b1;
            end else begin
              dvd_q   <= acc_q;
              dvs_q   <= x;
              prem_q  <= '0;
              cnt_q   <= '0;
              state_q <= StDiv;
            end
          end
        end
        StDiv: begin
          prem_q <= take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvd_q  <= {dvd_q[WIDTH-2:0], take};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          acc_q   <= dvd_q;
          out     <= dvd_q;
          rem     <= prem_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_divacc.sv
// Directed bench for divacc: a table of load/divide operations with hand-computed
// results, plus sequences for busy-time input ignoring and mid-operation reset.
module tb_divacc;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] x;
  logic [W-1:0] out;
  logic [W-1:0] rem;
  logic         busy;
  logic         divzero;

  int n_checks = 0;
  int n_pass   = 0;

  divacc #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .x       (x),
    .out     (out),
    .rem     (rem),
    .busy    (busy),
    .divzero (divzero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       e;
    logic [7:0] xv;
    int         exp_out;
    int         exp_rem;
    int         exp_dz;
    int         exp_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Present one request for one edge, then count busy cycles (bounded) until idle.
  task automatic apply(input logic ld, input logic e, input logic [7:0] xv, output int bcnt);
    @(negedge clk);
    load = ld;
    en   = e;
    x    = xv;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    en   = 1'b0;
    x    = '0;
    bcnt = 0;
    while (busy && bcnt < 40) begin
      bcnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int bc;

    vecs[0]  = '{1'b1, 1'b0, 8'd200, 200, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 8'd7,   28,  4, 0, 9};
    vecs[2]  = '{1'b0, 1'b1, 8'd3,   9,   1, 0, 9};
    vecs[3]  = '{1'b0, 1'b1, 8'd1,   9,   0, 0, 9};
    vecs[4]  = '{1'b0, 1'b1, 8'd20,  0,   9, 0, 9};
    vecs[5]  = '{1'b1, 1'b0, 8'd50,  50,  0, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 8'd0,   50,  0, 1, 0};
    vecs[7]  = '{1'b0, 1'b1, 8'd5,   10,  0, 1, 9};
    vecs[8]  = '{1'b1, 1'b1, 8'd77,  77,  0, 1, 0};
    vecs[9]  = '{1'b0, 1'b1, 8'd255, 0,   77, 1, 9};
    vecs[10] = '{1'b1, 1'b0, 8'd255, 255, 0, 1, 0};

    reset = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    x     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset out", int'(out), 1);
    check("reset rem", int'(rem), 0);
    check("reset busy", int'(busy), 0);
    check("reset divzero", int'(divzero), 0);

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].ld, vecs[i].e, vecs[i].xv, bc);
      check($sformatf("vec%0d busy cycles", i), bc, vecs[i].exp_busy);
      check($sformatf("vec%0d out", i), int'(out), vecs[i].exp_out);
      check($sformatf("vec%0d rem", i), int'(rem), vecs[i].exp_rem);
      check($sformatf("vec%0d divzero", i), int'(divzero), vecs[i].exp_dz);
    end

    // Inputs held active throughout busy must not disturb the divide or start another.
    apply(1'b1, 1'b0, 8'd100, bc);
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
    x    = 8'd4;
    @(posedge clk);
    @(negedge clk);
    load = 1'b1;
    en   = 1'b1;
    x    = 8'd9;
    bc   = 0;
    while (busy && bc < 40) begin
      bc++;
      @(negedge clk);
    end
    load = 1'b0;
    en   = 1'b0;
    x    = '0;
    check("ignore busy cycles", bc, 9);
    check("ignore out", int'(out), 25);
    check("ignore rem", int'(rem), 0);
    @(negedge clk);
    check("ignore no restart", int'(busy), 0);
    check("ignore out held", int'(out), 25);

    // Reset in the fourth divide cycle aborts with no partial result.
    apply(1'b1, 1'b0, 8'd255, bc);
    @(negedge clk);
    en = 1'b1;
    x  = 8'd2;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    x  = '0;
    check("midreset busy before", int'(busy), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midreset out", int'(out), 1);
    check("midreset rem", int'(rem), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset divzero", int'(divzero), 0);
    repeat (12) @(negedge clk);
    check("midreset out stays", int'(out), 1);

    // Accumulator restarts at 1 after reset: 1 / 3 = 0 r 1.
    apply(1'b0, 1'b1, 8'd3, bc);
    check("post reset busy cycles", bc, 9);
    check("post reset out", int'(out), 0);
    check("post reset rem", int'(rem), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
